tpu_mac_unit: RTL
=================

// Module: tpu_mac_unit
// PURPOSE
//  Parametrised minifloat multiply-accumulate lane for the TPU datapath; successor to the fixed 8-bit sync-strobed MAC.
//  Accepts operand pairs over a valid/ready handshake, multiplies them exactly in a 2-stage pipeline and accumulates signed fixed-point.
//  A 'last' beat closes a dot product: the sum is held in a result register and the accumulator restarts.
//  Sits between the operand feeder and the result collector; the result is read OUT_W bits at a time through a slice select.
// PARAMETERS
//  EXP_W  4   exponent field width; operand width is OP_W = 1+EXP_W+MAN_W
//  MAN_W  3   mantissa field width
//  ACC_W  32  signed accumulator/result width; must be a multiple of OUT_W
//  OUT_W  16  width of the out slice; SEL_W = max(1, clog2(ACC_W/OUT_W))
// PORTS
//  clk       in   1      clock, all state updates on rising edge
//  reset     in   1      synchronous, active-high reset
//  clr       in   1      sync clear: zero the accumulator, clear error, flush the pipeline
//  in_valid  in   1      operand beat valid
//  in_ready  out  1      unit can accept a beat
//  in_last   in   1      beat is the final term of the dot product
//  input1    in   OP_W   operand A {sign, exp, man}
//  input2    in   OP_W   operand B
//  res_valid out  1      result register holds an unread result
//  res_ready in   1      collector consumes the result
//  out_sel   in   SEL_W  slice select, 0 = least significant
//  out       out  OUT_W  comb: res_data[out_sel*OUT_W +: OUT_W]
//  error     out  1      sticky accumulate-overflow flag
// BEHAVIOUR
//  Decode: mag = (e==0) ? m : {1,m} << (e-1). Zero = e==0,m==0. No inf/NaN. Product is exact:
//    prod = (sA^sB ? -1 : +1) * magA*magB, width 2*(MAN_W+2^EXP_W-1) bits (36 at default), sign-extended.
//  Stage 1 (accept edge k): register sign, magA*magB significand product, exp sum, last.
//  Stage 2 (edge k+1): shift, add to acc. If last: res_data <= acc+prod, res_valid <= 1, acc <= 0.
//  Latency: a beat accepted on edge k is reflected in acc/res_data after edge k+1. Throughput: 1 beat/cycle.
//  Stall: stall = res_valid & ~res_ready. While stall, in_ready=0 and both stages hold.
//    in_ready = ~stall & ~clr & ~reset.
//  Result handshake: res_valid & res_ready on an edge clears res_valid, unless a new last completes on the same edge,
//    in which case res_valid stays 1 with new data. res_data is held stable while res_valid & ~res_ready.
//  FSM (acc_state): IDLE (acc==0, no terms) -> RUN on first accepted beat; RUN -> IDLE when last retires;
//    IDLE/RUN -> HOLD when last retires while the previous result is still unread (stall); HOLD -> IDLE on res_ready.
//  Overflow: acc+prod outside signed ACC_W range -> error <= 1 (sticky until reset/clr); result per CONFIGURATION.
//  Last on a single-beat product: res_data = prod (acc treated as 0).
//  clr: acc <= 0, error <= 0, stage-1 valid <= 0; res_valid/res_data untouched. A beat offered with clr is not accepted.
//  reset (also mid-operation): acc=0, res_data=0, res_valid=0, error=0, stage regs invalid, state IDLE;
//    in_ready=0 during reset, 1 on the first cycle after.
//  out_sel >= ACC_W/OUT_W selects slice 0.
// CONFIGURATION
//  TPU_MAC_SATURATE_EN defined: on overflow, acc/res clamp to 2^(ACC_W-1)-1 or -2^(ACC_W-1).
//  Undefined: two's-complement wrap modulo 2^ACC_W. error is set in both builds.
// STRUCTURE
//  Package tpu_mac_pkg: OP_W/PROD_W derivation functions, acc_state_t enum {IDLE,RUN,HOLD},
//    minifloat field-extract helpers shared with the feeder.
//  One sub-module: tpu_minifloat_mul (decode + exact signed product, comb), instantiated in stage 1/2.
// TESTING (defaults EXP_W=4, MAN_W=3, ACC_W=32, OUT_W=16)
//  1) 0x08*0x09 last -> res_valid 2 edges later, res_data=0x00000048, out_sel=0 -> 0x0048, error=0.
//  2) 0x88*0x09 last -> res_data=0xFFFFFFB8; out_sel=1 -> 0xFFFF.
//  3) 0x01*0x01, 0x08*0x08 last back-to-back -> res_data=65; next dot product starts from 0.
//  4) 0x7F*0x7F twice, last -> error=1; SATURATE_EN: 0x7FFFFFFF, else wrapped value; clr -> error=0.
//  5) Result unread, res_ready=0, second last retires -> in_ready=0, first result held; res_ready=1 -> new result.
//  6) reset asserted mid dot product -> all outputs 0, next product 0x08*0x09 last gives 0x48.

Source files
------------

// File: rtl/tpu_mac_pkg.sv
// Shared definitions for the minifloat MAC lane: width derivations, accumulator FSM states
// and minifloat field extractors (also used by the operand feeder).
package tpu_mac_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } acc_state_t;

    function automatic int op_w(int exp_w, int man_w);
        return 1 + exp_w + man_w;
    endfunction

    // Unsigned magnitude width of an exact product: both operands at max exponent.
    function automatic int prod_w(int exp_w, int man_w);
        return 2 * (man_w + (1 << exp_w) - 1);
    endfunction

    // Signed sum wide enough that acc + signed product never wraps before the range check.
    function automatic int sum_w(int acc_w, int pw);
        return ((acc_w > pw + 1) ? acc_w : pw + 1) + 1;
    endfunction

    function automatic int sel_w(int acc_w, int out_w);
        return (acc_w / out_w > 1) ? $clog2(acc_w / out_w) : 1;
    endfunction

    function automatic logic mf_sign(logic [31:0] op, int exp_w, int man_w);
        return op[exp_w + man_w];
    endfunction

    function automatic logic [31:0] mf_exp(logic [31:0] op, int exp_w, int man_w);
        return (op >> man_w) & ((32'd1 << exp_w) - 32'd1);
    endfunction

    function automatic logic [31:0] mf_man(logic [31:0] op, int man_w);
        return op & ((32'd1 << man_w) - 32'd1);
    endfunction

endpackage

// File: rtl/tpu_minifloat_mul.sv
// Minifloat decode and exact product front half: sign, significand product and combined
// shift amount. The caller applies the shift (kept outside so it can sit in a later stage).
module tpu_minifloat_mul
    import tpu_mac_pkg::*;
#(
    parameter int EXP_W = 4,
    parameter int MAN_W = 3,
    localparam int OP_W  = op_w(EXP_W, MAN_W),
    localparam int SIG_W = 2 * (MAN_W + 1),
    localparam int SH_W  = EXP_W + 1
) (
    input  logic [OP_W-1:0]  a,
    input  logic [OP_W-1:0]  b,
    output logic             sign,
    output logic [SIG_W-1:0] sig_prod,
    output logic [SH_W-1:0]  shamt
);

    logic [EXP_W-1:0] ea, eb, sh_a, sh_b;
    logic [MAN_W-1:0] ma, mb;
    logic [MAN_W:0]   sig_a, sig_b;

    assign ea = EXP_W'(mf_exp(32'(a), EXP_W, MAN_W));
    assign eb = EXP_W'(mf_exp(32'(b), EXP_W, MAN_W));
    assign ma = MAN_W'(mf_man(32'(a), MAN_W));
    assign mb = MAN_W'(mf_man(32'(b), MAN_W));

    // Subnormals (e==0) carry no hidden bit and no shift; normals shift by e-1.
    always_comb begin
        sig_a    = {(ea != '0), ma};
        sig_b    = {(eb != '0), mb};
        sh_a     = (ea == '0) ? '0 : ea - 1'b1;
        sh_b     = (eb == '0) ? '0 : eb - 1'b1;
        sign     = mf_sign(32'(a), EXP_W, MAN_W) ^ mf_sign(32'(b), EXP_W, MAN_W);
        sig_prod = SIG_W'(sig_a) * SIG_W'(sig_b);
        shamt    = SH_W'(sh_a) + SH_W'(sh_b);
    end

endmodule

// File: rtl/tpu_mac_unit.sv
// Minifloat multiply-accumulate lane: 2-stage exact product, signed fixed-point accumulate,
// result register read by slice. Define TPU_MAC_SATURATE_EN to clamp on overflow instead of wrapping.
module tpu_mac_unit
    import tpu_mac_pkg::*;
#(
    parameter int EXP_W = 4,
    parameter int MAN_W = 3,
    parameter int ACC_W = 32,
    parameter int OUT_W = 16,
    localparam int OP_W  = op_w(EXP_W, MAN_W),
    localparam int SEL_W = sel_w(ACC_W, OUT_W)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    input  logic [OP_W-1:0]  input1,
    input  logic [OP_W-1:0]  input2,
    output logic             res_valid,
    input  logic             res_ready,
    input  logic [SEL_W-1:0] out_sel,
    output logic [OUT_W-1:0] out,
    output logic             error
);

    localparam int SIG_W  = 2 * (MAN_W + 1);
    localparam int SH_W   = EXP_W + 1;
    localparam int PROD_W = prod_w(EXP_W, MAN_W);
    localparam int SUM_W  = sum_w(ACC_W, PROD_W);
    localparam int NSL    = ACC_W / OUT_W;

    acc_state_t state, state_nxt;
    logic stall, accept;

    logic             m_sign;
    logic [SIG_W-1:0] m_sig;
    logic [SH_W-1:0]  m_shamt;

    logic             s1_vld, s1_sign, s1_last;
    logic [SIG_W-1:0] s1_sig;
    logic [SH_W-1:0]  s1_shamt;

    logic [PROD_W-1:0]       mag;
    logic signed [PROD_W:0]  prod;
    logic signed [SUM_W-1:0] sum;
    logic                    ovf;
    logic signed [ACC_W-1:0] acc, acc_nxt;
    logic [ACC_W-1:0]        res_data;
    logic [SEL_W-1:0]        sel_eff;

    tpu_minifloat_mul #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_mul (
        .a        (input1),
        .b        (input2),
        .sign     (m_sign),
        .sig_prod (m_sig),
        .shamt    (m_shamt)
    );

    assign accept = in_valid & in_ready;

    // Stage 2: apply exponent shift, form the signed product and the range-checked sum.
    always_comb begin
        mag  = PROD_W'(s1_sig) << s1_shamt;
        prod = s1_sign ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
        sum  = SUM_W'(acc) + SUM_W'(prod);
        ovf  = !((&sum[SUM_W-1:ACC_W-1]) || !(|sum[SUM_W-1:ACC_W-1]));
`ifdef TPU_MAC_SATURATE_EN
        if (ovf)
            acc_nxt = sum[SUM_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        else
            acc_nxt = sum[ACC_W-1:0];
`else
        acc_nxt = sum[ACC_W-1:0];
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld    <= 1'b0;
            s1_sign   <= 1'b0;
            s1_last   <= 1'b0;
            s1_sig    <= '0;
            s1_shamt  <= '0;
            acc       <= '0;
            res_data  <= '0;
            res_valid <= 1'b0;
            error     <= 1'b0;
        end else begin
            if (res_valid && res_ready)
                res_valid <= 1'b0;
            if (clr) begin
                acc    <= '0;
                error  <= 1'b0;
                s1_vld <= 1'b0;
            end else if (!stall) begin
                s1_vld <= accept;
                if (accept) begin
                    s1_sign  <= m_sign;
                    s1_sig   <= m_sig;
                    s1_shamt <= m_shamt;
                    s1_last  <= in_last;
                end
                if (s1_vld) begin
                    if (ovf)
                        error <= 1'b1;
                    // A retiring last overrides the read-clear above, keeping res_valid high.
                    if (s1_last) begin
                        res_data  <= acc_nxt;
                        res_valid <= 1'b1;
                        acc       <= '0;
                    end else begin
                        acc <= acc_nxt;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (clr)
            state_nxt = IDLE;
        else if (s1_vld && s1_last && stall)
            state_nxt = HOLD;
        else if (accept)
            state_nxt = RUN;
        else if (s1_vld && s1_last)
            state_nxt = IDLE;
    end

    // HOLD always has an unread result, so it folds into the stall term without changing it.
    always_comb begin
        stall    = (res_valid || state == HOLD) && !res_ready;
        in_ready = !stall && !clr && !reset;
    end

    always_comb begin
        sel_eff = (int'(out_sel) < NSL) ? out_sel : '0;
        out     = res_data[int'(sel_eff)*OUT_W +: OUT_W];
    end

endmodule
